// File: rtl/ifu_fetch_queue_pkg.sv
// Shared types and constants for the IFU prefetch queue.
// The output bus width, reset PC and queue entry layout live here.
package ifu_pkg;

    localparam int          FS_TO_DS_BUS_W = 65;
    localparam logic [31:0] IFU_RESET_PC   = 32'h1c00_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        filled;
        logic        adef;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Fetch-stage signal bundle: redirect in, split SRAM request/response, and the ID handshake.
// master = the fetch queue, slave = the surrounding pipeline and memory.
interface ifu_fetch_queue_if;

    logic                              br_taken;
    logic [31:0]                       br_target;
    logic                              inst_req;
    logic [31:0]                       inst_addr;
    logic                              inst_addr_ok;
    logic                              inst_data_ok;
    logic [31:0]                       inst_rdata;
    logic                              fs_to_ds_valid;
    logic [ifu_pkg::FS_TO_DS_BUS_W-1:0] fs_to_ds_bus;
    logic                              ds_allowin;

    modport master (
        input  br_taken, br_target, inst_addr_ok, inst_data_ok, inst_rdata, ds_allowin,
        output inst_req, inst_addr, fs_to_ds_valid, fs_to_ds_bus
    );

    modport slave (
        output br_taken, br_target, inst_addr_ok, inst_data_ok, inst_rdata, ds_allowin,
        input  inst_req, inst_addr, fs_to_ds_valid, fs_to_ds_bus
    );

endinterface

// File: rtl/ifu_fetch_queue.sv
// Decoupled prefetch queue: issue at N, data_ok at N+1 earliest, presented to ID at N+2; requests stop when DEPTH entries are allocated or stale responses are pending.
// IFU_ADEF_EN: a misaligned fetch PC allocates one pre-filled adef entry and stalls fetch until the next redirect.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic               clk,
    input  logic               resetn,
    ifu_fetch_queue_if.master  bus
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [31:0]                 fpc_q, fpc_d;
    fq_entry_t                   ent_q [DEPTH];
    logic [PW-1:0]               head_q, fill_q, tail_q;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               out_q, out_d;
    logic [CW-1:0]               disc_q, disc_d;
    logic [FS_TO_DS_BUS_W-1:0]   last_q;

    logic                        can_alloc, req, mem_issue, adef_alloc, alloc;
    logic                        head_vld, pop, fill;
    logic [31:0]                 addr;
    logic                        head_adef;
    logic [FS_TO_DS_BUS_W-1:0]   head_bus;
    fq_entry_t                   head_ent;

    // Gating with resetn keeps inst_req low while reset is held and lets it rise in the first cycle after release.
    assign can_alloc = resetn && (cnt_q != DEPTH_C) && (disc_q == '0);

`ifdef IFU_ADEF_EN
    logic adef_stall_q;
    logic fpc_bad;

    assign fpc_bad    = (fpc_q[1:0] != 2'b00);
    assign req        = can_alloc && !fpc_bad;
    assign adef_alloc = can_alloc && fpc_bad && !adef_stall_q && !bus.br_taken;
    assign addr       = fpc_q;
    assign head_adef  = head_ent.adef;
`else
    assign req        = can_alloc;
    assign adef_alloc = 1'b0;
    assign addr       = {fpc_q[31:2], 2'b00};
    assign head_adef  = 1'b0;
`endif

    assign mem_issue = req && bus.inst_addr_ok;
    assign alloc     = mem_issue || adef_alloc;

    assign head_ent  = ent_q[head_q];
    assign head_vld  = (cnt_q != '0) && head_ent.filled;
    assign head_bus  = {head_adef, head_ent.pc, head_ent.inst};
    assign pop       = bus.fs_to_ds_valid && bus.ds_allowin;
    assign fill      = bus.inst_data_ok && (disc_q == '0) && !bus.br_taken;

    assign bus.inst_req       = req;
    assign bus.inst_addr      = addr;
    assign bus.fs_to_ds_valid = head_vld && !bus.br_taken;
    assign bus.fs_to_ds_bus   = head_vld ? head_bus : last_q;

    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        disc_d = disc_q;
        fpc_d  = fpc_q;
        if (bus.br_taken) begin
            // Everything still owed by memory, including this cycle's issue, becomes stale.
            cnt_d  = '0;
            out_d  = '0;
            disc_d = disc_q + out_q + CW'(mem_issue) - CW'(bus.inst_data_ok);
            fpc_d  = bus.br_target;
        end else begin
            cnt_d = cnt_q + CW'(alloc) - CW'(pop);
            out_d = out_q + CW'(mem_issue) - CW'(fill);
            if (bus.inst_data_ok && (disc_q != '0)) begin
                disc_d = disc_q - CW'(1);
            end
            if (mem_issue) begin
                fpc_d = fpc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fpc_q  <= RESET_PC;
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            disc_q <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            fpc_q  <= fpc_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            disc_q <= disc_d;
            if (head_vld) begin
                last_q <= head_bus;
            end
            if (bus.br_taken) begin
                head_q <= '0;
                fill_q <= '0;
                tail_q <= '0;
            end else begin
                if (alloc) begin
                    ent_q[tail_q] <= '{pc: addr, inst: 32'h0, filled: adef_alloc, adef: adef_alloc};
                    tail_q        <= tail_q + PW'(1);
                end
                if (fill) begin
                    ent_q[fill_q].inst   <= bus.inst_rdata;
                    ent_q[fill_q].filled <= 1'b1;
                    fill_q               <= fill_q + PW'(1);
                end
                if (pop) begin
                    head_q <= head_q + PW'(1);
                end
            end
        end
    end

`ifdef IFU_ADEF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adef_stall_q <= 1'b0;
        end else if (bus.br_taken) begin
            adef_stall_q <= 1'b0;
        end else if (adef_alloc) begin
            adef_stall_q <= 1'b1;
        end
    end
`endif

    // A response with nothing outstanding (live or stale) means the memory side broke protocol.
    a_data_ok_has_owner: assert property (
        @(posedge clk) disable iff (!resetn)
        bus.inst_data_ok |-> ((disc_q != '0) || (out_q != '0))
    );

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: in-order memory model plus a stream-level reference of the expected PC sequence.
module tb_ifu_fetch_queue;
    import ifu_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    ifu_fetch_queue_if fq_if ();

    ifu_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(IFU_RESET_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (fq_if)
    );

    typedef struct {
        logic [31:0] tgt;
        int          n;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    int n_tests, n_fail;

    // Memory: in-order list of accepted addresses, each tagged with the stream epoch it belonged to.
    logic [31:0] mq_a [$];
    int          mq_ep [$];

    // Reference: the stream after the latest redirect is target, target+4, ...
    int          epoch, occ, fill_cnt, cyc, first_vld_cyc;
    int          deliv, issued, ep_deliv, stale_drops, req_seen, adef_deliv;
    logic [31:0] fetch_pc, exp_pc, ep_first, ep_last;
    logic [64:0] last_shown, adef_bus;
    bit          chk_en;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq_a.delete();
        mq_ep.delete();
        epoch = 0; occ = 0; fill_cnt = 0; cyc = 0; first_vld_cyc = -1;
        ep_deliv = 0; ep_first = 32'hdead_beef; ep_last = 32'hdead_beef;
        fetch_pc = IFU_RESET_PC; exp_pc = IFU_RESET_PC; last_shown = '0;
    endtask

    // Called at a falling edge; drives one cycle, checks, accounts for the rising edge, returns at the next falling edge.
    task automatic tick(input bit a_ok, input bit d_want, input bit allow, input bit br, input logic [31:0] tgt);
        int          stale;
        bit          dok, issue, exp_req, exp_vld, popm;
        logic [64:0] exp_bus;
        dok = d_want && (mq_a.size() > 0);
        fq_if.inst_addr_ok = a_ok;
        fq_if.ds_allowin   = allow;
        fq_if.br_taken     = br;
        fq_if.br_target    = tgt;
        fq_if.inst_data_ok = dok;
        fq_if.inst_rdata   = dok ? memfn(mq_a[0]) : $urandom;
        #1;
        stale = 0;
        foreach (mq_ep[i]) if (mq_ep[i] != epoch) stale++;
        exp_req = (stale == 0) && (occ < DEPTH);
`ifdef IFU_ADEF_EN
        exp_req = exp_req && (fetch_pc[1:0] == 2'b00);
`endif
        exp_vld = (fill_cnt > 0) && !br;
        exp_bus = {1'b0, exp_pc, memfn(exp_pc)};
        if (fq_if.fs_to_ds_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        cyc++;
        if (chk_en) begin
            chk("inst_req", fq_if.inst_req, exp_req);
            if (exp_req) chk("inst_addr", fq_if.inst_addr, fetch_pc);
            chk("fs_to_ds_valid", fq_if.fs_to_ds_valid, exp_vld);
            if (fill_cnt > 0) begin
                chk("fs_to_ds_bus", fq_if.fs_to_ds_bus, exp_bus);
                last_shown = exp_bus;
            end else begin
                chk("bus_hold", fq_if.fs_to_ds_bus, last_shown);
            end
        end else begin
            if (fq_if.inst_req) req_seen++;
            if (fq_if.fs_to_ds_valid && allow) begin
                adef_deliv++;
                adef_bus = fq_if.fs_to_ds_bus;
            end
        end
        issue = fq_if.inst_req && a_ok;
        if (dok) begin
            if (mq_ep[0] == epoch && !br) fill_cnt++;
            else stale_drops++;
            void'(mq_a.pop_front());
            void'(mq_ep.pop_front());
        end
        if (issue) begin
            mq_a.push_back(fq_if.inst_addr);
            mq_ep.push_back(epoch);
            issued++;
        end
        popm = exp_vld && allow;
        if (br) begin
            epoch++; occ = 0; fill_cnt = 0;
            fetch_pc = tgt; exp_pc = tgt;
            ep_deliv = 0; ep_first = 32'hdead_beef; ep_last = 32'hdead_beef;
        end else begin
            if (issue) begin
                occ++;
                fetch_pc += 32'd4;
            end
            if (popm) begin
                occ--; fill_cnt--;
                if (ep_deliv == 0) ep_first = exp_pc;
                ep_last = exp_pc;
                ep_deliv++; deliv++;
                exp_pc += 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rtick(input bit allow_br);
        logic [31:0] r;
        r = $urandom;
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
             allow_br && ($urandom_range(0, 63) == 0), {r[31:2], 2'b00});
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        fq_if.inst_addr_ok = 1'b0; fq_if.inst_data_ok = 1'b0; fq_if.inst_rdata = '0;
        fq_if.ds_allowin = 1'b0; fq_if.br_taken = 1'b0; fq_if.br_target = '0;
        #1;
        chk("rst_inst_req", fq_if.inst_req, 1'b0);
        chk("rst_valid", fq_if.fs_to_ds_valid, 1'b0);
        chk("rst_bus", fq_if.fs_to_ds_bus, 65'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        resetn = 1'b1;
    endtask

    vec_t tbl [4];

    initial begin
        int d0, i0, sd;
        n_tests = 0; n_fail = 0; deliv = 0; issued = 0; stale_drops = 0;
        req_seen = 0; adef_deliv = 0; adef_bus = '0; chk_en = 1'b1;
        tbl[0] = '{32'h1c00_1000, 8, 32'h1c00_1000, 32'h1c00_101c};
        tbl[1] = '{32'h1c00_fff0, 6, 32'h1c00_fff0, 32'h1c01_0004};
        tbl[2] = '{32'hffff_fff8, 4, 32'hffff_fff8, 32'h0000_0004};
        tbl[3] = '{32'h1c00_0000, 5, 32'h1c00_0000, 32'h1c00_0010};

        // Back-to-back memory, ID always ready: one instruction per cycle from the third cycle.
        do_reset();
        d0 = deliv;
        repeat (25) tick(1, 1, 1, 0, '0);
        chk("first_valid_cycle", first_vld_cyc, 2);
        chk("throughput", deliv - d0, 23);

        // ID stalled: exactly DEPTH requests, then a lossless in-order drain.
        do_reset();
        i0 = issued;
        repeat (10) tick(1, 1, 0, 0, '0);
        chk("stall_issues", issued - i0, DEPTH);
        chk("stall_req_low", fq_if.inst_req, 1'b0);
        d0 = deliv;
        repeat (10) tick(1, 1, 1, 0, '0);
        chk("drain_count", deliv - d0, 10);

        // Redirect with three requests outstanding.
        do_reset();
        repeat (3) tick(1, 0, 1, 0, '0);
        sd = stale_drops;
        tick(0, 0, 1, 1, 32'h1c00_0100);
        for (int c = 0; c < 50 && ep_deliv == 0; c++) tick(1, 1, 1, 0, '0);
        chk("redir_first_pc", ep_first, 32'h1c00_0100);
        chk("redir_stale_dropped", stale_drops - sd, 3);

        // Redirect in the same cycle as an accepted request and a response.
        do_reset();
        repeat (2) tick(1, 0, 1, 0, '0);
        sd = stale_drops; i0 = issued;
        tick(1, 1, 1, 1, 32'h1c00_0200);
        chk("same_cycle_issue", issued - i0, 1);
        for (int c = 0; c < 60 && ep_deliv < 5; c++) tick(1, 1, 1, 0, '0);
        chk("same_cycle_first_pc", ep_first, 32'h1c00_0200);
        chk("same_cycle_last_pc", ep_last, 32'h1c00_0210);
        chk("same_cycle_dropped", stale_drops - sd, 3);

        // Redirect table under random memory and ID timing.
        for (int v = 0; v < 4; v++) begin
            repeat (5) rtick(0);
            tick($urandom_range(0, 1), $urandom_range(0, 1), 1, 1, tbl[v].tgt);
            for (int c = 0; c < 400 && ep_deliv < tbl[v].n; c++) rtick(0);
            chk("tbl_first_pc", ep_first, tbl[v].exp_first);
            chk("tbl_last_pc", ep_last, tbl[v].exp_last);
        end

        // 1000 fetches with random stalls and occasional redirects.
        d0 = deliv;
        for (int c = 0; c < 20000 && (deliv - d0) < 1000; c++) rtick(1);
        chk("random_fetches_done", (deliv - d0) >= 1000, 1'b1);

        // Reset in the middle of traffic, then resume.
        repeat (7) rtick(0);
        do_reset();
        for (int c = 0; c < 30 && ep_deliv < 4; c++) tick(1, 1, 1, 0, '0);
        chk("post_reset_last_pc", ep_last, 32'h1c00_000c);

`ifdef IFU_ADEF_EN
        do_reset();
        chk_en = 1'b0;
        tick(0, 1, 1, 1, 32'h1c00_0102);
        req_seen = 0; adef_deliv = 0;
        repeat (8) tick(1, 1, 1, 0, '0);
        chk("adef_no_req", req_seen, 0);
        chk("adef_entries", adef_deliv, 1);
        chk("adef_bus", adef_bus, {1'b1, 32'h1c00_0102, 32'h0});
        last_shown = {1'b1, 32'h1c00_0102, 32'h0};
        chk_en = 1'b1;
        tick(0, 1, 1, 1, 32'h1c00_0200);
        for (int c = 0; c < 30 && ep_deliv < 3; c++) tick(1, 1, 1, 0, '0);
        chk("adef_resume_pc", ep_first, 32'h1c00_0200);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
